// File: rtl/game_pkg.sv
// Shared types and helpers for the number-guessing game: tracker states,
// hint encoding and the per-difficulty target limit.
package game_pkg;

  typedef enum logic [1:0] {
    DRAW   = 2'd0,
    PLAY   = 2'd1,
    LOCKED = 2'd2
  } gt_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    LOW     = 2'b01,
    HIGH    = 2'b10,
    CORRECT = 2'b11
  } hint_t;

  localparam int unsigned LFSR_W = 10;
  // Galois right-shift mask for x^10 + x^7 + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 10'h240;
  localparam logic [2:0] COUNT_MAX = 3'd7;

  function automatic logic [9:0] digit_limit(input logic [1:0] digits);
    logic [9:0] limit;
    case (digits)
      2'd1:    limit = 10'd9;
      2'd2:    limit = 10'd99;
      2'd3:    limit = 10'd999;
      default: limit = 10'd0;
    endcase
    return limit;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] value);
    return (value == COUNT_MAX) ? value : value + 3'd1;
  endfunction

endpackage

// File: rtl/target_lfsr.sv
// Free-running 10-bit Galois LFSR that supplies candidate targets every cycle.
module target_lfsr
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h001
) (
  input  logic              clk,
  input  logic              restart_n,
  output logic [LFSR_W-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      value <= LFSR_SEED;
    end else begin
      value <= {1'b0, value[LFSR_W-1:1]} ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/guess_tracker.sv
// Per-level guess evaluator: draws a target, scores confirmed guesses and
// keeps the miss count, round count and countdown timer for the difficulty FSM.
module guess_tracker
  import game_pkg::*;
#(
  parameter int          TICK_DIV   = 50_000_000,
  parameter int          TIMER_INIT = 99,
  parameter logic [9:0]  LFSR_SEED  = 10'h001
) (
  input  logic       clk,
  input  logic       restart_n,
  input  logic       confirm,
  input  logic [9:0] guess,
  input  logic [1:0] max_digit,
  input  logic [2:0] max_incorrect_guesses,
  output logic [2:0] incorrect_guesses,
  output logic [2:0] round,
  output logic [6:0] timer,
  output logic [1:0] hint,
  output logic [9:0] target
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(TICK_DIV - 1);
  localparam logic [6:0]         TIMER_RELOAD = 7'(TIMER_INIT);

  gt_state_t          state_q, state_d;
  hint_t              hint_q, hint_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [6:0]         timer_q, timer_d;
  logic [2:0]         inc_q, inc_d;
  logic [2:0]         round_q, round_d;
  logic [9:0]         target_q, target_d;
  logic [1:0]         md_q;
  logic               confirm_q;

  logic [9:0] lfsr_value;
  logic [9:0] limit;
  logic       confirm_edge;
  logic       level_change;
  logic       lock_cond;
  logic       tick;

  target_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .restart_n (restart_n),
    .value     (lfsr_value)
  );

  assign limit        = digit_limit(max_digit);
  assign confirm_edge = confirm & ~confirm_q;
  assign level_change = (max_digit != md_q);
  assign tick         = (presc_q == PRESC_LAST);
  assign lock_cond    = (timer_q == 7'd0)
                     || ((max_incorrect_guesses != 3'd0) && (inc_q >= max_incorrect_guesses))
                     || (max_digit == 2'd0);

  always_comb begin
    // NOTE: every next value defaults to hold first, so no branch can infer a latch.
    state_d  = state_q;
    hint_d   = hint_q;
    presc_d  = presc_q;
    timer_d  = timer_q;
    inc_d    = inc_q;
    round_d  = round_q;
    target_d = target_q;

    if (level_change) begin
      // A new difficulty wins over any confirm edge or tick in the same cycle.
      presc_d = '0;
      timer_d = TIMER_RELOAD;
      inc_d   = '0;
      round_d = '0;
      hint_d  = NONE;
      state_d = (max_digit == 2'd0) ? LOCKED : DRAW;
    end else if (lock_cond || (state_q == LOCKED)) begin
      // Once locked, only a level change or reset releases the tracker.
      state_d = LOCKED;
    end else begin
      if (tick) begin
        presc_d = '0;
        timer_d = timer_q - 7'd1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end

      case (state_q)
        DRAW: begin
          if (lfsr_value <= limit) begin
            target_d = lfsr_value;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          if (confirm_edge) begin
            if (guess == target_q) begin
              round_d = sat_inc(round_q);
              hint_d  = CORRECT;
              state_d = DRAW;
            end else begin
              inc_d  = sat_inc(inc_q);
              hint_d = (guess < target_q) ? LOW : HIGH;
            end
          end
        end
        default: state_d = DRAW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= DRAW;
    end else begin
      state_q <= state_d;
    end
  end

  // The difficulty copy resets to 0, so a nonzero max_digit at release counts as a level change.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      hint_q    <= NONE;
      presc_q   <= '0;
      timer_q   <= TIMER_RELOAD;
      inc_q     <= '0;
      round_q   <= '0;
      target_q  <= '0;
      md_q      <= 2'd0;
      confirm_q <= 1'b0;
    end else begin
      hint_q    <= hint_d;
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      inc_q     <= inc_d;
      round_q   <= round_d;
      target_q  <= target_d;
      md_q      <= max_digit;
      confirm_q <= confirm;
    end
  end

  assign incorrect_guesses = inc_q;
  assign round             = round_q;
  assign timer             = timer_q;
  assign hint              = hint_q;
  assign target            = target_q;

endmodule

// File: tb/tb_guess_tracker.sv
// Scoreboard bench for guess_tracker: a slow-tick instance for gameplay and a
// fast-tick instance (TICK_DIV=4) for timer expiry, both on shared inputs.
module tb_guess_tracker;
  import game_pkg::*;

  localparam int         SLOW_DIV   = 256;
  localparam int         FAST_DIV   = 4;
  localparam int         TIMER_INIT = 99;
  localparam logic [9:0] SEED       = 10'h3FF;

  logic       clk       = 1'b0;
  logic       restart_n = 1'b0;
  logic       confirm   = 1'b0;
  logic       confirm_f = 1'b0;
  logic [9:0] guess     = '0;
  logic [1:0] max_digit = 2'd1;
  logic [2:0] max_inc   = 3'd0;

  logic [2:0] inc_s, round_s, inc_f, round_f;
  logic [6:0] timer_s, timer_f;
  logic [1:0] hint_s, hint_f;
  logic [9:0] target_s, target_f;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] hint;
    logic [2:0] inc;
    logic [2:0] rnd;
  } exp_t;
  exp_t sb[$];

  logic [9:0] m_lfsr;
  logic [9:0] cur_t;
  logic [9:0] draw_start;

  always #5 clk = ~clk;

  guess_tracker #(.TICK_DIV(SLOW_DIV), .TIMER_INIT(TIMER_INIT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .restart_n(restart_n), .confirm(confirm), .guess(guess),
    .max_digit(max_digit), .max_incorrect_guesses(max_inc),
    .incorrect_guesses(inc_s), .round(round_s), .timer(timer_s), .hint(hint_s), .target(target_s)
  );

  guess_tracker #(.TICK_DIV(FAST_DIV), .TIMER_INIT(TIMER_INIT), .LFSR_SEED(SEED)) dut_fast (
    .clk(clk), .restart_n(restart_n), .confirm(confirm_f), .guess(guess),
    .max_digit(max_digit), .max_incorrect_guesses(max_inc),
    .incorrect_guesses(inc_f), .round(round_f), .timer(timer_f), .hint(hint_f), .target(target_f)
  );

  // Reference LFSR: x^10 + x^7 + 1, Galois form, shifting toward bit 0.
  function automatic logic [9:0] lfsr_step(input logic [9:0] v);
    logic [9:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 10'b10_0100_0000;
    return n;
  endfunction

  always @(posedge clk or negedge restart_n) begin
    if (!restart_n) m_lfsr <= SEED;
    else            m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every confirm rising edge seen by the DUT yields one scored (or ignored) response.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      if (!restart_n) begin
        prev = 1'b0;
      end else if (confirm && !prev) begin
        prev = 1'b1;
        @(negedge clk);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL monitor: confirm edge with no expected response queued");
        end else begin
          e = sb.pop_front();
          check({e.name, "_hint"},  hint_s,  e.hint);
          check({e.name, "_inc"},   inc_s,   e.inc);
          check({e.name, "_round"}, round_s, e.rnd);
        end
      end else begin
        prev = confirm;
      end
    end
  end

  task automatic press(input string name, input logic [9:0] g, input hint_t h,
                       input logic [2:0] inc, input logic [2:0] rnd);
    exp_t e;
    @(negedge clk);
    guess   = g;
    confirm = 1'b1;
    e.name = name; e.hint = h; e.inc = inc; e.rnd = rnd;
    sb.push_back(e);
    @(negedge clk);
    confirm    = 1'b0;
    draw_start = m_lfsr;
  endtask

  // Called in the first DRAW cycle; start is the LFSR value in that cycle.
  task automatic draw_check(input string name, input logic [9:0] start, input logic [9:0] lim);
    logic [9:0] v;
    int k;
    v = start;
    k = 0;
    while (v > lim && k < 2000) begin
      v = lfsr_step(v);
      k++;
    end
    repeat (k + 1) @(negedge clk);
    cur_t = v;
    check(name, target_s, v);
  endtask

  task automatic level(input string name, input logic [1:0] md, input logic [2:0] mi);
    @(negedge clk);
    max_digit = md;
    max_inc   = mi;
    @(negedge clk);
    draw_start = m_lfsr;
    check({name, "_inc"},   inc_s,   3'd0);
    check({name, "_round"}, round_s, 3'd0);
    check({name, "_hint"},  hint_s,  NONE);
    check({name, "_timer"}, timer_s, 7'd99);
  endtask

  initial begin : watchdog
    #900_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    int m;
    #12;
    check("rst_inc",     inc_s,    3'd0);
    check("rst_round",   round_s,  3'd0);
    check("rst_timer",   timer_s,  7'd99);
    check("rst_hint",    hint_s,   NONE);
    check("rst_target",  target_s, 10'd0);
    check("rst_timer_f", timer_f,  7'd99);

    @(negedge clk);
    restart_n  = 1'b1;
    draw_start = m_lfsr;
    draw_check("draw_l1_first", draw_start, 10'd9);

    press("low",        cur_t - 10'd1, LOW,     3'd1, 3'd0);
    press("high",       cur_t + 10'd1, HIGH,    3'd2, 3'd0);
    press("above_lim",  10'd1023,      HIGH,    3'd3, 3'd0);
    press("correct1",   cur_t,         CORRECT, 3'd3, 3'd1);
    draw_check("draw_l1_r1", draw_start, 10'd9);
    for (int i = 2; i <= 5; i++) begin
      press("correct_n", cur_t, CORRECT, 3'd3, 3'(i));
      draw_check("draw_l1_rn", draw_start, 10'd9);
    end

    level("lvl2", 2'd2, 3'd0);
    draw_check("draw_l2", draw_start, 10'd99);
    for (int i = 1; i <= 8; i++) begin
      press("miss_sat", cur_t + 10'd1, HIGH, (i > 7) ? 3'd7 : 3'(i), 3'd0);
    end
    press("correct_l2", cur_t, CORRECT, 3'd7, 3'd1);
    draw_check("draw_l2_r1", draw_start, 10'd99);

    level("lvl3", 2'd3, 3'd3);
    draw_check("draw_l3", draw_start, 10'd999);
    press("l3_low",     cur_t - 10'd1, LOW,  3'd1, 3'd0);
    press("l3_high",    cur_t + 10'd1, HIGH, 3'd2, 3'd0);
    press("l3_high2",   10'd1023,      HIGH, 3'd3, 3'd0);
    press("l3_ignored", cur_t,         HIGH, 3'd3, 3'd0);

    level("lvl1b", 2'd1, 3'd0);
    draw_check("draw_l1b", draw_start, 10'd9);
    press("pre_reset", cur_t + 10'd1, HIGH, 3'd1, 3'd0);

    @(negedge clk);
    restart_n = 1'b0;
    #1;
    check("mid_rst_inc",    inc_s,    3'd0);
    check("mid_rst_round",  round_s,  3'd0);
    check("mid_rst_timer",  timer_s,  7'd99);
    check("mid_rst_hint",   hint_s,   NONE);
    check("mid_rst_target", target_s, 10'd0);
    @(negedge clk);
    restart_n  = 1'b1;
    draw_start = m_lfsr;
    draw_check("draw_after_rst", draw_start, 10'd9);

    @(negedge clk);
    guess   = cur_t + 10'd1;
    confirm = 1'b1;
    sb.push_back('{name: "held", hint: HIGH, inc: 3'd1, rnd: 3'd0});
    repeat (10) @(negedge clk);
    confirm = 1'b0;
    check("held_inc", inc_s, 3'd1);

    @(negedge clk);
    max_digit = 2'd2;
    @(negedge clk);
    m = 0;
    check("fast_reload", timer_f, 7'd99);
    while (timer_f != 7'd0 && m < 600) begin
      @(negedge clk);
      m++;
    end
    check("fast_expire_cycles", m, 396);
    repeat (20) @(negedge clk);
    check("fast_hold0", timer_f, 7'd0);
    confirm_f = 1'b1;
    @(negedge clk);
    confirm_f = 1'b0;
    check("fast_lock_inc",   inc_f,   3'd0);
    check("fast_lock_round", round_f, 3'd0);
    check("fast_lock_hint",  hint_f,  NONE);

    level("lvl0", 2'd0, 3'd0);
    press("lvl0_ignored", 10'd5, NONE, 3'd0, 3'd0);
    repeat (300) @(negedge clk);
    check("lvl0_timer_hold", timer_s, 7'd99);

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
